slave_in_port: RTL and testbench

//  Slave-side receiver of the serial bus. Deserialises the address, burst length and write data that the

---
 rtl/slave_in_port.sv | 190 +++++++++++++++++++
 tb/tb_slave_in_port.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_in_port.sv
// rtl/slave_in_port.sv - serial bus slave receiver: deserialises address, burst length and write data
// into parallel memory write/read strobes and drives this slave's s_ready bit.
module slave_in_port #(
  parameter int SLAVE_ADDR_SIZE = 12,
  parameter int WORD_SIZE       = 8,
  parameter int BURST_SIZE      = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       slave_select,
  input  logic                       addr_bus,
  input  logic                       burst_size_bus,
  input  logic                       w_data_bus,
  input  logic                       read_en,
  input  logic                       m_valid,
  input  logic                       m_b_tx_valid,
  input  logic                       split_on,
  input  logic                       mem_wr_ready,
  output logic                       s_ready,
  output logic [SLAVE_ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]       mem_wdata,
  output logic                       mem_wr,
  output logic                       mem_rd,
  output logic [BURST_SIZE-1:0]      rd_len,
  output logic                       s_busy,
  output logic                       rx_err
);

  localparam int ACW = (SLAVE_ADDR_SIZE > 1) ? $clog2(SLAVE_ADDR_SIZE) : 1;
  localparam int LCW = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;
  localparam int DCW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  localparam logic [ACW-1:0] ADDR_LAST = ACW'(SLAVE_ADDR_SIZE - 1);
  localparam logic [LCW-1:0] LEN_LAST  = LCW'(BURST_SIZE - 1);
  localparam logic [DCW-1:0] BIT_LAST  = DCW'(WORD_SIZE - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR_RX  = 3'd1;
  localparam logic [2:0] DECODE   = 3'd2;
  localparam logic [2:0] BURST_RX = 3'd3;
  localparam logic [2:0] DATA_RX  = 3'd4;
  localparam logic [2:0] WR_HOLD  = 3'd5;

  logic [2:0]                 state;
  logic [2:0]                 state_nxt;
  logic [ACW-1:0]             addr_cnt;
  logic [SLAVE_ADDR_SIZE-1:0] addr_sr;
  logic [LCW-1:0]             len_cnt;
  logic [BURST_SIZE-1:0]      len_sr;
  logic [BURST_SIZE-1:0]      burst_len;
  logic [BURST_SIZE-1:0]      word_idx;
  logic [DCW-1:0]             bit_cnt;
  logic [WORD_SIZE-1:0]       data_sr;
  logic                       hold_last;

  logic                       abort;
  logic                       data_fire;
  logic                       word_done;
  logic                       last_word;
  logic                       len_done;
  logic [WORD_SIZE-1:0]       word_val;
  logic [BURST_SIZE-1:0]      len_raw;
  logic [BURST_SIZE-1:0]      len_val;

  assign s_busy = (state != IDLE);

  always_comb begin
    abort     = (state != IDLE) && (!slave_select || split_on);
    data_fire = (state == DATA_RX) && m_valid && s_ready;
    word_done = data_fire && (bit_cnt == BIT_LAST);
    last_word = ((word_idx + BURST_SIZE'(1)) == burst_len);
    len_done  = (state == BURST_RX) && (len_cnt == LEN_LAST);
    // Include the bit arriving this cycle so the completed value is usable immediately.
    word_val           = data_sr;
    word_val[bit_cnt]  = w_data_bus;
    len_raw            = len_sr;
    len_raw[len_cnt]   = burst_size_bus;
    len_val            = (len_raw == '0) ? BURST_SIZE'(1) : len_raw;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (slave_select) state_nxt = ADDR_RX;
      ADDR_RX:  if (addr_cnt == ADDR_LAST) state_nxt = DECODE;
      DECODE: begin
        if (m_b_tx_valid)  state_nxt = BURST_RX;
        else if (read_en)  state_nxt = IDLE;
        else               state_nxt = DATA_RX;
      end
      BURST_RX: if (len_done) state_nxt = read_en ? IDLE : DATA_RX;
      DATA_RX: begin
        if (word_done) begin
          if (!mem_wr_ready)  state_nxt = WR_HOLD;
          else if (last_word) state_nxt = IDLE;
        end
      end
      WR_HOLD:  if (mem_wr_ready) state_nxt = hold_last ? IDLE : DATA_RX;
      default:  state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      addr_sr   <= '0;
      len_cnt   <= '0;
      len_sr    <= '0;
      burst_len <= '0;
      word_idx  <= '0;
      bit_cnt   <= '0;
      data_sr   <= '0;
      hold_last <= 1'b0;
      s_ready   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;
      rd_len    <= '0;
      rx_err    <= 1'b0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt != WR_HOLD);
      rx_err  <= abort;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      // An abort discards everything in flight, including a word completing this cycle.
      if (!abort) begin
        case (state)
          IDLE: begin
            if (slave_select) addr_cnt <= '0;
          end
          ADDR_RX: begin
            addr_sr[addr_cnt] <= addr_bus;
            addr_cnt          <= addr_cnt + ACW'(1);
          end
          DECODE: begin
            if (m_b_tx_valid) begin
              len_cnt <= '0;
            end else begin
              burst_len <= BURST_SIZE'(1);
              word_idx  <= '0;
              bit_cnt   <= '0;
              if (read_en) begin
                mem_rd   <= 1'b1;
                rd_len   <= BURST_SIZE'(1);
                mem_addr <= addr_sr;
              end
            end
          end
          BURST_RX: begin
            len_sr[len_cnt] <= burst_size_bus;
            len_cnt         <= len_cnt + LCW'(1);
            if (len_done) begin
              burst_len <= len_val;
              word_idx  <= '0;
              bit_cnt   <= '0;
              if (read_en) begin
                mem_rd   <= 1'b1;
                rd_len   <= len_val;
                mem_addr <= addr_sr;
              end
            end
          end
          DATA_RX: begin
            if (data_fire) begin
              data_sr[bit_cnt] <= w_data_bus;
              bit_cnt          <= bit_cnt + DCW'(1);
            end
            if (word_done) begin
              bit_cnt   <= '0;
              mem_wdata <= word_val;
              mem_addr  <= addr_sr + SLAVE_ADDR_SIZE'(word_idx);
              mem_wr    <= 1'b1;
              hold_last <= last_word;
              if (!last_word) word_idx <= word_idx + BURST_SIZE'(1);
            end
          end
          WR_HOLD: begin
            mem_wr <= !mem_wr_ready;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slave_in_port.sv
// tb/tb_slave_in_port.sv - table, hand-written and randomized checks of slave_in_port against a queue model
module tb_slave_in_port;
  localparam int AW = 12;
  localparam int WW = 8;
  localparam int BW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          slave_select, addr_bus, burst_size_bus, w_data_bus;
  logic          read_en, m_valid, m_b_tx_valid, split_on, mem_wr_ready;
  logic          s_ready, mem_wr, mem_rd, s_busy, rx_err;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic [BW-1:0] rd_len;

  slave_in_port #(.SLAVE_ADDR_SIZE(AW), .WORD_SIZE(WW), .BURST_SIZE(BW)) dut (
    .clk(clk), .rst(rst), .slave_select(slave_select), .addr_bus(addr_bus),
    .burst_size_bus(burst_size_bus), .w_data_bus(w_data_bus), .read_en(read_en),
    .m_valid(m_valid), .m_b_tx_valid(m_b_tx_valid), .split_on(split_on),
    .mem_wr_ready(mem_wr_ready), .s_ready(s_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd), .rd_len(rd_len),
    .s_busy(s_busy), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] obs_wa[$], exp_wa[$], obs_ra[$], exp_ra[$];
  logic [WW-1:0] obs_wd[$], exp_wd[$];
  logic [BW-1:0] obs_rl[$], exp_rl[$];
  logic [WW-1:0] txw[$];
  int            rx_err_cnt = 0;
  bit            both_seen = 1'b0;
  bit            prev_wr = 1'b0;
  bit            rand_ready = 1'b0;

  // Bus monitor: a write is a rising edge of mem_wr, a read is any cycle with mem_rd.
  always @(negedge clk) begin
    if (rst) begin
      prev_wr = 1'b0;
    end else begin
      if (mem_wr && !prev_wr) begin
        obs_wa.push_back(mem_addr);
        obs_wd.push_back(mem_wdata);
      end
      prev_wr = mem_wr;
      if (mem_rd) begin
        obs_ra.push_back(mem_addr);
        obs_rl.push_back(rd_len);
      end
      if (rx_err) rx_err_cnt++;
      if (mem_wr && mem_rd) both_seen = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) mem_wr_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic send_hdr(input bit rd, input bit btx, input logic [AW-1:0] a, input logic [BW-1:0] l);
    slave_select = 1'b1;
    read_en      = rd;
    m_b_tx_valid = btx;
    addr_bus     = 1'($urandom_range(0, 1));
    step();
    for (int i = 0; i < AW; i++) begin
      addr_bus = a[i];
      step();
    end
    addr_bus = 1'b0;
    step();
    if (btx) begin
      for (int i = 0; i < BW; i++) begin
        burst_size_bus = l[i];
        step();
      end
    end
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    int guard = 0;
    while ((!s_ready || (gaps && $urandom_range(0, 3) == 0)) && guard < 100) begin
      m_valid    = 1'b0;
      w_data_bus = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    if (guard >= 100) chk("s_ready_timeout", 32'(s_ready), 32'd1);
    m_valid    = 1'b1;
    w_data_bus = b;
    step();
    m_valid = 1'b0;
  endtask

  task automatic finish_txn();
    int guard = 0;
    while (s_busy && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) chk("busy_timeout", 32'(s_busy), 32'd0);
    slave_select = 1'b0;
    read_en      = 1'b0;
    m_b_tx_valid = 1'b0;
    split_on     = 1'b0;
    m_valid      = 1'b0;
    repeat (3) step();
  endtask

  task automatic do_txn(input bit rd, input bit btx, input logic [AW-1:0] a, input logic [BW-1:0] l,
                        input bit gaps);
    send_hdr(rd, btx, a, l);
    if (!rd) begin
      foreach (txw[k]) begin
        for (int b = 0; b < WW; b++) send_bit(txw[k][b], gaps);
      end
    end
    finish_txn();
  endtask

  // Reference: a write of n words lands at consecutive addresses modulo the address space.
  task automatic model_txn(input bit rd, input bit btx, input logic [AW-1:0] a, input logic [BW-1:0] l);
    int n;
    n = btx ? ((l == 0) ? 1 : int'(l)) : 1;
    if (rd) begin
      exp_ra.push_back(a);
      exp_rl.push_back(BW'(n));
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_wa.push_back(AW'((int'(a) + i) % (1 << AW)));
        exp_wd.push_back(txw[i]);
      end
    end
  endtask

  task automatic check_events(input string tag, input int exp_rx);
    chk({tag, " wr_count"}, 32'(obs_wa.size()), 32'(exp_wa.size()));
    for (int i = 0; i < obs_wa.size() && i < exp_wa.size(); i++) begin
      chk($sformatf("%s wr_addr[%0d]", tag, i), 32'(obs_wa[i]), 32'(exp_wa[i]));
      chk($sformatf("%s wr_data[%0d]", tag, i), 32'(obs_wd[i]), 32'(exp_wd[i]));
    end
    chk({tag, " rd_count"}, 32'(obs_ra.size()), 32'(exp_ra.size()));
    for (int i = 0; i < obs_ra.size() && i < exp_ra.size(); i++) begin
      chk($sformatf("%s rd_addr[%0d]", tag, i), 32'(obs_ra[i]), 32'(exp_ra[i]));
      chk($sformatf("%s rd_len[%0d]", tag, i), 32'(obs_rl[i]), 32'(exp_rl[i]));
    end
    chk({tag, " rx_err_count"}, 32'(rx_err_cnt), 32'(exp_rx));
    chk({tag, " wr_rd_overlap"}, 32'(both_seen), 32'd0);
    obs_wa.delete(); obs_wd.delete(); obs_ra.delete(); obs_rl.delete();
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete(); exp_rl.delete();
    rx_err_cnt = 0;
    both_seen  = 1'b0;
  endtask

  typedef struct {
    string         name;
    bit            rd;
    bit            btx;
    logic [AW-1:0] addr;
    logic [BW-1:0] len;
    int            nw;
    logic [WW-1:0] w0, w1, w2;
    logic [AW-1:0] ea0, ea1, ea2;
    int            exp_nrd;
    logic [BW-1:0] exp_rdlen;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [WW-1:0] bp_word;
    logic [WW-1:0] ws[3];
    logic [AW-1:0] eas[3];

    tbl[0] = '{"single_wr",   1'b0, 1'b0, 12'h0A5, 15'd0,      1, 8'h3C, 8'h00, 8'h00, 12'h0A5, 12'h000, 12'h000, 0, 15'd0};
    tbl[1] = '{"single_rd",   1'b1, 1'b0, 12'h123, 15'd0,      0, 8'h00, 8'h00, 8'h00, 12'h000, 12'h000, 12'h000, 1, 15'd1};
    tbl[2] = '{"burst_wrap",  1'b0, 1'b1, 12'hFFE, 15'd3,      3, 8'h11, 8'h22, 8'h33, 12'hFFE, 12'hFFF, 12'h000, 0, 15'd0};
    tbl[3] = '{"rd_len0",     1'b1, 1'b1, 12'h400, 15'd0,      0, 8'h00, 8'h00, 8'h00, 12'h000, 12'h000, 12'h000, 1, 15'd1};
    tbl[4] = '{"rd_len_max",  1'b1, 1'b1, 12'h7A0, 15'h7FFF,   0, 8'h00, 8'h00, 8'h00, 12'h000, 12'h000, 12'h000, 1, 15'h7FFF};
    tbl[5] = '{"wr_len0",     1'b0, 1'b1, 12'h010, 15'd0,      1, 8'h5A, 8'h00, 8'h00, 12'h010, 12'h000, 12'h000, 0, 15'd0};

    rst = 1'b1;
    slave_select = 1'b0; addr_bus = 1'b0; burst_size_bus = 1'b0; w_data_bus = 1'b0;
    read_en = 1'b0; m_valid = 1'b0; m_b_tx_valid = 1'b0; split_on = 1'b0; mem_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst s_ready", 32'(s_ready), 32'd0);
    chk("rst mem_wr", 32'(mem_wr), 32'd0);
    chk("rst mem_rd", 32'(mem_rd), 32'd0);
    chk("rst s_busy", 32'(s_busy), 32'd0);
    chk("rst rx_err", 32'(rx_err), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst rd_len", 32'(rd_len), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("post_rst s_ready", 32'(s_ready), 32'd1);
    chk("post_rst s_busy", 32'(s_busy), 32'd0);
    step();

    for (int v = 0; v < 6; v++) begin
      ws[0] = tbl[v].w0; ws[1] = tbl[v].w1; ws[2] = tbl[v].w2;
      eas[0] = tbl[v].ea0; eas[1] = tbl[v].ea1; eas[2] = tbl[v].ea2;
      txw.delete();
      for (int k = 0; k < tbl[v].nw; k++) begin
        txw.push_back(ws[k]);
        exp_wa.push_back(eas[k]);
        exp_wd.push_back(ws[k]);
      end
      if (tbl[v].exp_nrd != 0) begin
        exp_ra.push_back(tbl[v].addr);
        exp_rl.push_back(tbl[v].exp_rdlen);
      end
      do_txn(tbl[v].rd, tbl[v].btx, tbl[v].addr, tbl[v].len, 1'b0);
      check_events(tbl[v].name, 0);
    end

    // Read strobe appears in the cycle right after DECODE and lasts one cycle.
    send_hdr(1'b1, 1'b0, 12'h123, 15'd0);
    slave_select = 1'b0;
    @(negedge clk);
    chk("rd_timing mem_rd", 32'(mem_rd), 32'd1);
    chk("rd_timing mem_addr", 32'(mem_addr), 32'h123);
    chk("rd_timing mem_wr", 32'(mem_wr), 32'd0);
    step();
    @(negedge clk);
    chk("rd_timing mem_rd_drop", 32'(mem_rd), 32'd0);
    finish_txn();
    exp_ra.push_back(12'h123); exp_rl.push_back(15'd1);
    check_events("rd_timing", 0);

    // Backpressure: word held four cycles, then released.
    mem_wr_ready = 1'b0;
    bp_word = 8'hA5;
    send_hdr(1'b0, 1'b0, 12'h200, 15'd0);
    for (int b = 0; b < WW; b++) send_bit(bp_word[b], 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("bp s_ready[%0d]", k), 32'(s_ready), 32'd0);
      chk($sformatf("bp mem_wr[%0d]", k), 32'(mem_wr), 32'd1);
      chk($sformatf("bp mem_addr[%0d]", k), 32'(mem_addr), 32'h200);
      chk($sformatf("bp mem_wdata[%0d]", k), 32'(mem_wdata), 32'hA5);
      step();
    end
    mem_wr_ready = 1'b1;
    @(negedge clk);
    chk("bp handshake mem_wr", 32'(mem_wr), 32'd1);
    step();
    slave_select = 1'b0;
    @(negedge clk);
    chk("bp release mem_wr", 32'(mem_wr), 32'd0);
    chk("bp release s_ready", 32'(s_ready), 32'd1);
    chk("bp release s_busy", 32'(s_busy), 32'd0);
    finish_txn();
    exp_wa.push_back(12'h200); exp_wd.push_back(8'hA5);
    check_events("backpressure", 0);

    // Abort by dropping slave_select mid-address.
    slave_select = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      addr_bus = 1'b1;
      step();
    end
    slave_select = 1'b0;
    step();
    @(negedge clk);
    chk("abort_addr rx_err", 32'(rx_err), 32'd1);
    chk("abort_addr s_busy", 32'(s_busy), 32'd0);
    step();
    @(negedge clk);
    chk("abort_addr rx_err_drop", 32'(rx_err), 32'd0);
    finish_txn();
    check_events("abort_addr", 1);

    // Split after five data bits.
    send_hdr(1'b0, 1'b0, 12'h055, 15'd0);
    for (int b = 0; b < 5; b++) send_bit(1'b1, 1'b0);
    split_on = 1'b1; m_valid = 1'b1; w_data_bus = 1'b1;
    step();
    split_on = 1'b0; m_valid = 1'b0; slave_select = 1'b0;
    finish_txn();
    check_events("split_5bits", 1);

    // Split coinciding with the last bit of the second word: first word stays written.
    bp_word = 8'hC3;
    send_hdr(1'b0, 1'b1, 12'h300, 15'd2);
    for (int b = 0; b < WW; b++) send_bit(bp_word[b], 1'b0);
    for (int b = 0; b < WW - 1; b++) send_bit(1'b0, 1'b0);
    split_on = 1'b1; m_valid = 1'b1; w_data_bus = 1'b1;
    step();
    split_on = 1'b0; m_valid = 1'b0; slave_select = 1'b0;
    finish_txn();
    exp_wa.push_back(12'h300); exp_wd.push_back(8'hC3);
    check_events("split_word_end", 1);

    txw.delete(); txw.push_back(8'h96);
    model_txn(1'b0, 1'b0, 12'h0AB, 15'd0);
    do_txn(1'b0, 1'b0, 12'h0AB, 15'd0, 1'b0);
    check_events("after_abort", 0);

    // Reset in the middle of data reception.
    send_hdr(1'b0, 1'b0, 12'h0F0, 15'd0);
    for (int b = 0; b < 3; b++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("mid_rst s_busy", 32'(s_busy), 32'd0);
    chk("mid_rst mem_wr", 32'(mem_wr), 32'd0);
    rst = 1'b0; slave_select = 1'b0;
    step();
    @(negedge clk);
    chk("mid_rst s_ready", 32'(s_ready), 32'd1);
    finish_txn();
    check_events("mid_rst", 0);

    // Randomized transactions with gaps and random memory backpressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      bit            rd, btx;
      logic [AW-1:0] a;
      logic [BW-1:0] l;
      int            n;
      rd  = ($urandom_range(0, 2) == 0);
      btx = ($urandom_range(0, 1) == 1);
      a   = AW'($urandom);
      l   = rd ? BW'($urandom) : BW'($urandom_range(0, 4));
      n   = btx ? ((l == 0) ? 1 : int'(l)) : 1;
      txw.delete();
      if (!rd) for (int k = 0; k < n; k++) txw.push_back(WW'($urandom));
      model_txn(rd, btx, a, l);
      do_txn(rd, btx, a, l, 1'b1);
      check_events($sformatf("rand%0d", t), 0);
    end
    rand_ready = 1'b0;
    mem_wr_ready = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
